// File: rtl/carregador_matrizes.sv
// Serial loader: assembles two flattened 5x5 signed matrices (A then B, column-major)
// and offers them downstream with valid/ready. Optional abort input: CARREGADOR_ABORTO_EN.
module carregador_matrizes #(
  parameter int LARGURA = 8,
  parameter int N_ELEM  = 25
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LARGURA-1:0]         entrada_dado,
  input  logic                       entrada_valida,
  output logic                       entrada_pronta,
  output logic [LARGURA*N_ELEM-1:0]  matriz_a,
  output logic [LARGURA*N_ELEM-1:0]  matriz_b,
  output logic                       saida_valida,
`ifdef CARREGADOR_ABORTO_EN
  input  logic                       abortar,
`endif
  input  logic                       saida_pronta
);

  localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(N_ELEM - 1);

  typedef enum logic [1:0] {
    CARREGA_A = 2'd0,
    CARREGA_B = 2'd1,
    PRONTO    = 2'd2
  } estado_t;

  estado_t                      state_q, state_d;
  logic [CW-1:0]                contador_q, contador_d;
  logic [LARGURA*N_ELEM-1:0]    matriz_a_q, matriz_a_d;
  logic [LARGURA*N_ELEM-1:0]    matriz_b_q, matriz_b_d;
  logic                         transfer;

  // Handshake flags come from registered state only, so no input-to-output path exists.
  assign entrada_pronta = (state_q != PRONTO);
  assign saida_valida   = (state_q == PRONTO);
  assign matriz_a       = matriz_a_q;
  assign matriz_b       = matriz_b_q;
  assign transfer       = entrada_valida && entrada_pronta;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    contador_d = contador_q;
    matriz_a_d = matriz_a_q;
    matriz_b_d = matriz_b_q;

    unique case (state_q)
      CARREGA_A, CARREGA_B: begin
        if (transfer) begin
          if (state_q == CARREGA_A) matriz_a_d[LARGURA*int'(contador_q) +: LARGURA] = entrada_dado;
          else                      matriz_b_d[LARGURA*int'(contador_q) +: LARGURA] = entrada_dado;
          if (contador_q == ULTIMO) begin
            contador_d = '0;
            state_d    = (state_q == CARREGA_A) ? CARREGA_B : PRONTO;
          end else begin
            contador_d = contador_q + 1'b1;
          end
        end
      end
      PRONTO:  if (saida_pronta) state_d = CARREGA_A;
      default: state_d = CARREGA_A;
    endcase

`ifdef CARREGADOR_ABORTO_EN
    // Abort drops the element of this cycle but keeps whatever was already stored.
    if (abortar) begin
      state_d    = CARREGA_A;
      contador_d = '0;
      matriz_a_d = matriz_a_q;
      matriz_b_d = matriz_b_q;
    end
`endif
  end

  // NOTE: the matrix registers are reset too, since zeroed outputs are part of the reset state.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= CARREGA_A;
      contador_q <= '0;
      matriz_a_q <= '0;
      matriz_b_q <= '0;
    end else begin
      state_q    <= state_d;
      contador_q <= contador_d;
      matriz_a_q <= matriz_a_d;
      matriz_b_q <= matriz_b_d;
    end
  end

endmodule

// File: tb/tb_carregador_matrizes.sv
// Directed bench for carregador_matrizes: load, placement, gaps, backpressure,
// signed extremes and reset mid-load (plus abort when CARREGADOR_ABORTO_EN is defined).
module tb_carregador_matrizes;

  localparam int LARGURA = 8;
  localparam int N_ELEM  = 25;
  localparam int W       = LARGURA * N_ELEM;

  logic               clock = 1'b0;
  logic               reset;
  logic [LARGURA-1:0] entrada_dado;
  logic               entrada_valida;
  logic               entrada_pronta;
  logic [W-1:0]       matriz_a;
  logic [W-1:0]       matriz_b;
  logic               saida_valida;
  logic               saida_pronta;
`ifdef CARREGADOR_ABORTO_EN
  logic               abortar = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_a, exp_b, snap_a, snap_b;

  always #5 clock = ~clock;

  carregador_matrizes #(.LARGURA(LARGURA), .N_ELEM(N_ELEM)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_dado   (entrada_dado),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .matriz_a       (matriz_a),
    .matriz_b       (matriz_b),
    .saida_valida   (saida_valida),
`ifdef CARREGADOR_ABORTO_EN
    .abortar        (abortar),
`endif
    .saida_pronta   (saida_pronta)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    entrada_valida = 1'b1;
    entrada_dado   = v;
    tick();
    entrada_valida = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic handshake();
    saida_pronta = 1'b1;
    tick();
    saida_pronta = 1'b0;
  endtask

  initial begin
    reset = 1'b1; entrada_dado = '0; entrada_valida = 1'b0; saida_pronta = 1'b0;
    do_reset();
    check("rst_saida_valida", W'(saida_valida), W'(0));
    check("rst_entrada_pronta", W'(entrada_pronta), W'(1));
    check("rst_matriz_a", matriz_a, '0);
    check("rst_matriz_b", matriz_b, '0);

    // Scenario 1: back-to-back stream 0..24 then 100..124
    for (int k = 0; k < N_ELEM; k++) begin
      exp_a[8*k +: 8] = 8'(k);
      exp_b[8*k +: 8] = 8'(100 + k);
    end
    entrada_valida = 1'b1;
    for (int k = 0; k < 2*N_ELEM; k++) begin
      entrada_dado = (k < N_ELEM) ? 8'(k) : 8'(100 + k - N_ELEM);
      tick();
      if (k == 2*N_ELEM - 2) check("s1_valid_low_at_49", W'(saida_valida), W'(0));
    end
    entrada_valida = 1'b0;
    check("s1_saida_valida", W'(saida_valida), W'(1));
    check("s1_entrada_pronta", W'(entrada_pronta), W'(0));
    check("s1_matriz_a", matriz_a, exp_a);
    check("s1_matriz_b", matriz_b, exp_b);

    // Scenario 2: element 7 (coluna 1, linha 2) at bits [56+:8]
    check("s2_elem7", W'(matriz_a[56 +: 8]), W'(7));

    // Scenario 4: backpressure in PRONTO, then handshake
    entrada_valida = 1'b1;
    entrada_dado   = 8'h55;
    for (int i = 0; i < 10; i++) tick();
    check("s4_hold_valida", W'(saida_valida), W'(1));
    check("s4_hold_pronta", W'(entrada_pronta), W'(0));
    check("s4_hold_a", matriz_a, exp_a);
    check("s4_hold_b", matriz_b, exp_b);
    entrada_dado = 8'hAA;
    handshake();
    check("s4_valida_drop", W'(saida_valida), W'(0));
    check("s4_pronta_back", W'(entrada_pronta), W'(1));
    check("s4_no_consume", matriz_a, exp_a);
    tick();
    entrada_valida = 1'b0;
    exp_a[7:0] = 8'hAA;
    check("s4_first_new_slot0", matriz_a, exp_a);

    // Scenario 3: gap stream, junk data on idle cycles
    do_reset();
    for (int k = 0; k < N_ELEM; k++) begin
      exp_a[8*k +: 8] = 8'(k);
      exp_b[8*k +: 8] = 8'(100 + k);
    end
    for (int k = 0; k < 2*N_ELEM; k++) begin
      entrada_valida = 1'b0;
      entrada_dado   = 8'hEE;
      tick();
      send((k < N_ELEM) ? 8'(k) : 8'(100 + k - N_ELEM));
      if (k == 2*N_ELEM - 2) check("s3_valid_low_at_49", W'(saida_valida), W'(0));
    end
    check("s3_saida_valida", W'(saida_valida), W'(1));
    check("s3_matriz_a", matriz_a, exp_a);
    check("s3_matriz_b", matriz_b, exp_b);
    handshake();

    // Scenario 5: signed extremes stored verbatim
    for (int k = 0; k < N_ELEM; k++) begin
      exp_a[8*k +: 8] = 8'(k + 1);
      exp_b[8*k +: 8] = 8'(200 + k);
    end
    exp_a[7:0]     = 8'h80; exp_a[192 +: 8] = 8'h7F;
    exp_b[7:0]     = 8'h80; exp_b[192 +: 8] = 8'h7F;
    for (int k = 0; k < N_ELEM; k++) send(exp_a[8*k +: 8]);
    for (int k = 0; k < N_ELEM; k++) send(exp_b[8*k +: 8]);
    check("s5_a0_min", W'(matriz_a[7:0]), W'(8'h80));
    check("s5_b24_max", W'(matriz_b[192 +: 8]), W'(8'h7F));
    check("s5_matriz_a", matriz_a, exp_a);
    check("s5_matriz_b", matriz_b, exp_b);
    handshake();

`ifdef CARREGADOR_ABORTO_EN
    // Abort after 30 elements: contents kept, counter and state restart
    snap_b = matriz_b;
    for (int k = 0; k < 30; k++) send(8'(8'h40 + k));
    for (int k = 0; k < N_ELEM; k++) exp_a[8*k +: 8] = 8'(8'h40 + k);
    exp_b = snap_b;
    for (int k = 0; k < 5; k++) exp_b[8*k +: 8] = 8'(8'h40 + N_ELEM + k);
    abortar = 1'b1; entrada_valida = 1'b1; entrada_dado = 8'h77;
    tick();
    abortar = 1'b0; entrada_valida = 1'b0;
    check("ab_saida_valida", W'(saida_valida), W'(0));
    check("ab_entrada_pronta", W'(entrada_pronta), W'(1));
    check("ab_keep_a", matriz_a, exp_a);
    check("ab_keep_b", matriz_b, exp_b);
    send(8'h11);
    exp_a[7:0] = 8'h11;
    check("ab_restart_slot0", matriz_a, exp_a);
    do_reset();
`endif

    // Scenario 6: reset after 30 elements, then a fresh full load
    for (int k = 0; k < 30; k++) send(8'(k + 7));
    snap_a = matriz_a;
    check("s6_partial_loaded", W'(snap_a[8*24 +: 8]), W'(31));
    do_reset();
    check("s6_rst_saida_valida", W'(saida_valida), W'(0));
    check("s6_rst_entrada_pronta", W'(entrada_pronta), W'(1));
    check("s6_rst_matriz_a", matriz_a, '0);
    check("s6_rst_matriz_b", matriz_b, '0);
    for (int k = 0; k < N_ELEM; k++) begin
      exp_a[8*k +: 8] = 8'(3 * k);
      exp_b[8*k +: 8] = 8'(255 - k);
    end
    for (int k = 0; k < N_ELEM; k++) send(exp_a[8*k +: 8]);
    for (int k = 0; k < N_ELEM; k++) send(exp_b[8*k +: 8]);
    check("s6_saida_valida", W'(saida_valida), W'(1));
    check("s6_matriz_a", matriz_a, exp_a);
    check("s6_matriz_b", matriz_b, exp_b);
    handshake();
    check("s6_after_hs", W'(saida_valida), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
